alarm_controller: RTL and testbench



---
 rtl/alarm_controller.sv | 128 ++++++++++++
 tb/tb_alarm_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencer for the 1 Hz clock domain: ring, snooze, stop, missed-alarm flag.
// Optional ALARM_BEEP_EN: ring output toggles every second while RINGING instead of staying high.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3,
  parameter int CNT_W          = 9
) (
  input  logic       Clk_1sec,
  input  logic       reset_in,
  input  logic [3:0] hours_in,
  input  logic [5:0] minutes_in,
  input  logic [5:0] seconds_in,
  input  logic       am_pm_in,
  input  logic [3:0] alarm_hour_in,
  input  logic [5:0] alarm_minute_in,
  input  logic       alarm_ampm_in,
  input  logic       alarm_enable_in,
  input  logic       snooze_in,
  input  logic       stop_in,
  output logic       alarm_ring_out,
  output logic       snooze_active_out,
  output logic [1:0] snooze_count_out,
  output logic       alarm_missed_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECONDS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECONDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       MAX_CNT     = 2'(MAX_SNOOZES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ring_q;
  logic             snooze_active_q;
  logic [1:0]       snooze_cnt_q;
  logic             missed_q;
  logic             match;

  // seconds_in == 0 makes the match a one-cycle event, so a stopped alarm cannot retrigger in the same minute.
  assign match = alarm_enable_in
               & (hours_in   == alarm_hour_in)
               & (minutes_in == alarm_minute_in)
               & (am_pm_in   == alarm_ampm_in)
               & (seconds_in == 6'd0);

  // NOTE: state and outputs share one clocked block with non-blocking assignments, so every output is a flop and reads the pre-edge state.
  always_ff @(posedge Clk_1sec) begin
    if (reset_in) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ring_q          <= 1'b0;
      snooze_active_q <= 1'b0;
      snooze_cnt_q    <= 2'd0;
      missed_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stop_in) missed_q <= 1'b0;
          if (match) begin
            state_q      <= RINGING;
            cnt_q        <= RING_LOAD;
            ring_q       <= 1'b1;
            snooze_cnt_q <= 2'd0;
          end
        end

        RINGING: begin
          if (!alarm_enable_in || stop_in) begin
            state_q <= IDLE;
            ring_q  <= 1'b0;
          end else if (snooze_in && (snooze_cnt_q < MAX_CNT)) begin
            state_q         <= SNOOZE;
            cnt_q           <= SNOOZE_LOAD;
            ring_q          <= 1'b0;
            snooze_active_q <= 1'b1;
            snooze_cnt_q    <= snooze_cnt_q + 2'd1;
          end else if (cnt_q == '0) begin
            state_q  <= IDLE;
            ring_q   <= 1'b0;
            missed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
`ifdef ALARM_BEEP_EN
            ring_q <= ~ring_q;
`else
            ring_q <= 1'b1;
`endif
          end
        end

        SNOOZE: begin
          if (!alarm_enable_in || stop_in) begin
            state_q         <= IDLE;
            snooze_active_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q         <= RINGING;
            cnt_q           <= RING_LOAD;
            ring_q          <= 1'b1;
            snooze_active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q         <= IDLE;
          ring_q          <= 1'b0;
          snooze_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_ring_out    = ring_q;
  assign snooze_active_out = snooze_active_q;
  assign snooze_count_out  = snooze_cnt_q;
  assign alarm_missed_out  = missed_q;
  assign state_out         = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: timeout, snooze, saturation, stop, disable, reset.
// Honours ALARM_BEEP_EN when computing the expected ring pattern.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [3:0] hours_in;
  logic [5:0] minutes_in;
  logic [5:0] seconds_in;
  logic       am_pm_in;
  logic [3:0] alarm_hour_in;
  logic [5:0] alarm_minute_in;
  logic       alarm_ampm_in;
  logic       alarm_enable_in;
  logic       snooze_in;
  logic       stop_in;
  logic       alarm_ring_out;
  logic       snooze_active_out;
  logic [1:0] snooze_count_out;
  logic       alarm_missed_out;
  logic [1:0] state_out;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  alarm_controller dut (
    .Clk_1sec          (clk),
    .reset_in          (reset_in),
    .hours_in          (hours_in),
    .minutes_in        (minutes_in),
    .seconds_in        (seconds_in),
    .am_pm_in          (am_pm_in),
    .alarm_hour_in     (alarm_hour_in),
    .alarm_minute_in   (alarm_minute_in),
    .alarm_ampm_in     (alarm_ampm_in),
    .alarm_enable_in   (alarm_enable_in),
    .snooze_in         (snooze_in),
    .stop_in           (stop_in),
    .alarm_ring_out    (alarm_ring_out),
    .snooze_active_out (snooze_active_out),
    .snooze_count_out  (snooze_count_out),
    .alarm_missed_out  (alarm_missed_out),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set after this are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int ring, input int sa,
                           input int cnt, input int miss);
    check({tag, ".state"},  32'(state_out),         32'(st));
    check({tag, ".ring"},   32'(alarm_ring_out),    32'(ring));
    check({tag, ".snz_act"},32'(snooze_active_out), 32'(sa));
    check({tag, ".snz_cnt"},32'(snooze_count_out),  32'(cnt));
    check({tag, ".missed"}, 32'(alarm_missed_out),  32'(miss));
  endtask

  // Expected ring level in the k-th cycle (1-based) of a RINGING stretch.
  function automatic int exp_ring(input int k);
`ifdef ALARM_BEEP_EN
    return k % 2;
`else
    return 1;
`endif
  endfunction

  initial begin
    reset_in        = 1'b1;
    hours_in        = 4'd3;
    minutes_in      = 6'd58;
    seconds_in      = 6'd59;
    am_pm_in        = 1'b1;
    alarm_hour_in   = 4'd3;
    alarm_minute_in = 6'd59;
    alarm_ampm_in   = 1'b1;
    alarm_enable_in = 1'b1;
    snooze_in       = 1'b0;
    stop_in         = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0);

    // 3:58:59 PM: no match yet
    tick();
    check_all("no_match", 0, 0, 0, 0, 0);

    // Unanswered alarm: 60 ring cycles then timeout with missed flag
    minutes_in = 6'd59;
    seconds_in = 6'd0;
    tick();
    seconds_in = 6'd1;
    check_all("t1_ring1", 1, 1, 0, 0, 0);
    for (int k = 2; k <= 60; k++) begin
      tick();
      check("t1_ring_k", 32'(alarm_ring_out), 32'(exp_ring(k)));
    end
    check("t1_state60", 32'(state_out), 32'd1);
    tick();
    check_all("t1_timeout", 0, 0, 0, 0, 1);

    // New event with missed still set, reset in the 10th ring cycle
    seconds_in = 6'd0;
    tick();
    seconds_in = 6'd1;
    check_all("t6_start", 1, 1, 0, 0, 1);
    repeat (9) tick();
    check("t6_ring10", 32'(alarm_ring_out), 32'(exp_ring(10)));
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check_all("t6_reset", 0, 0, 0, 0, 0);

    // Snooze at 5th ring cycle; 300 silent cycles; snooze ignored while snoozing
    seconds_in = 6'd0;
    tick();
    seconds_in = 6'd1;
    repeat (4) tick();
    check("t2_cycle5", 32'(state_out), 32'd1);
    snooze_in = 1'b1;
    tick();
    snooze_in = 1'b0;
    check_all("t2_snz", 2, 0, 1, 1, 0);
    for (int i = 2; i <= 300; i++) begin
      snooze_in = (i == 51);
      tick();
      check("t2_quiet", 32'({state_out, alarm_ring_out}), 32'({2'd2, 1'b0}));
    end
    snooze_in = 1'b0;
    check("t2_cnt_hold", 32'(snooze_count_out), 32'd1);
    tick();
    check_all("t2_back", 1, 1, 0, 1, 0);

    // Snoozes 2 and 3, then the 4th is ignored
    snooze_in = 1'b1;
    tick();
    snooze_in = 1'b0;
    check_all("t3_snz2", 2, 0, 1, 2, 0);
    repeat (299) tick();
    check("t3_still_snz2", 32'(state_out), 32'd2);
    tick();
    check_all("t3_back2", 1, 1, 0, 2, 0);
    snooze_in = 1'b1;
    tick();
    snooze_in = 1'b0;
    check_all("t3_snz3", 2, 0, 1, 3, 0);
    repeat (300) tick();
    check_all("t3_back3", 1, 1, 0, 3, 0);
    snooze_in = 1'b1;
    tick();
    snooze_in = 1'b0;
    check_all("t3_ignored", 1, exp_ring(2), 0, 3, 0);

    // Stop and snooze together: stop wins, count kept
    stop_in   = 1'b1;
    snooze_in = 1'b1;
    tick();
    stop_in   = 1'b0;
    snooze_in = 1'b0;
    check_all("t4_stop", 0, 0, 0, 3, 0);

    // Disable in the 100th snooze cycle, re-enable within the same minute
    seconds_in = 6'd0;
    tick();
    seconds_in = 6'd1;
    check_all("t5_start", 1, 1, 0, 0, 0);
    snooze_in = 1'b1;
    tick();
    snooze_in = 1'b0;
    check_all("t5_snz", 2, 0, 1, 1, 0);
    repeat (99) tick();
    check("t5_snz100", 32'(state_out), 32'd2);
    alarm_enable_in = 1'b0;
    tick();
    check_all("t5_disable", 0, 0, 0, 1, 0);
    alarm_enable_in = 1'b1;
    seconds_in      = 6'd30;
    repeat (3) tick();
    check_all("t5_reenable", 0, 0, 0, 1, 0);

    // Same time but AM: no match
    am_pm_in   = 1'b0;
    seconds_in = 6'd0;
    tick();
    check_all("t5_am", 0, 0, 0, 1, 0);

    // Next day 3:59:00 PM rings; let it time out, then stop clears missed
    am_pm_in = 1'b1;
    tick();
    seconds_in = 6'd1;
    check_all("t5_nextday", 1, 1, 0, 0, 0);
    repeat (59) tick();
    tick();
    check_all("t7_timeout", 0, 0, 0, 0, 1);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check_all("t7_clear", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
